// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with begin/data watchdogs. A grant is held until the
// transaction ends; stalled transactions are aborted with busError + endTransaction.

module bus_arbiter_lane #(
  parameter int IDXW = 2,
  parameter int LANE = 0
) (
  input  logic            grantEn,
  input  logic [IDXW-1:0] grantIdx,
  output logic            grant
);
  assign grant = grantEn && (grantIdx == IDXW'(LANE));
endmodule

module bus_arbiter #(
  parameter int NUM_MASTERS   = 4,
  parameter int BEGIN_TIMEOUT = 16,
  parameter int DATA_TIMEOUT  = 256
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] busRequestsIn,
  input  logic                   beginTransactionIn,
  input  logic                   endTransactionIn,
  input  logic                   dataValidIn,
  output logic [NUM_MASTERS-1:0] busGrantsOut,
  output logic                   busErrorOut,
  output logic                   endTransactionOut,
  output logic                   timeoutOut
);
  localparam int IDXW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int BCW  = ($clog2(BEGIN_TIMEOUT) > 0) ? $clog2(BEGIN_TIMEOUT) : 1;
  localparam int DCW  = ($clog2(DATA_TIMEOUT) > 0) ? $clog2(DATA_TIMEOUT) : 1;
  localparam logic [BCW-1:0] BC_LAST = BCW'(BEGIN_TIMEOUT - 1);
  localparam logic [DCW-1:0] DC_LAST = DCW'(DATA_TIMEOUT - 1);
  localparam logic [BCW-1:0] BC_MAX  = '1;
  localparam logic [DCW-1:0] DC_MAX  = '1;

  typedef enum logic [2:0] {IDLE, GRANT, ACTIVE, ERROR, ENDTX, RELEASE} state_t;

  state_t          state, stateNext;
  logic [IDXW-1:0] grantIdxReg, grantIdxNext;
  logic [IDXW-1:0] lastGrantReg, lastGrantNext;
  logic [BCW-1:0]  beginCountReg, beginCountNext;
  logic [DCW-1:0]  dataCountReg, dataCountNext;
  logic            timeoutReg, timeoutNext;

  logic            searchFound;
  logic [IDXW-1:0] searchIdx;
  logic [IDXW-1:0] candIdx;
  int              candInt;

  // Rotating search: first requester at or after lastGrant+1, wrapping.
  always_comb begin
    searchFound = 1'b0;
    searchIdx   = '0;
    candInt     = 0;
    candIdx     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      candInt = (int'(lastGrantReg) + 1 + i) % NUM_MASTERS;
      candIdx = IDXW'(candInt);
      if (!searchFound && busRequestsIn[candIdx]) begin
        searchFound = 1'b1;
        searchIdx   = candIdx;
      end
    end
  end

  always_comb begin
    stateNext      = state;
    grantIdxNext   = grantIdxReg;
    lastGrantNext  = lastGrantReg;
    beginCountNext = beginCountReg;
    dataCountNext  = dataCountReg;
    timeoutNext    = 1'b0;
    case (state)
      IDLE: begin
        if (searchFound) begin
          grantIdxNext   = searchIdx;
          lastGrantNext  = searchIdx;
          beginCountNext = '0;
          stateNext      = GRANT;
        end
      end
      GRANT: begin
        if (beginTransactionIn) begin
          stateNext      = ACTIVE;
          dataCountNext  = '0;
          beginCountNext = '0;
        end else if (!busRequestsIn[grantIdxReg]) begin
          stateNext      = RELEASE;
          beginCountNext = '0;
        end else if (beginCountReg == BC_LAST) begin
          stateNext      = RELEASE;
          timeoutNext    = 1'b1;
          beginCountNext = '0;
        end else begin
          beginCountNext = (beginCountReg == BC_MAX) ? beginCountReg : beginCountReg + BCW'(1);
        end
      end
      ACTIVE: begin
        if (endTransactionIn) begin
          stateNext = RELEASE;
        end else if (dataValidIn) begin
          dataCountNext = '0;
        end else if (dataCountReg == DC_LAST) begin
          stateNext   = ERROR;
          timeoutNext = 1'b1;
        end else begin
          dataCountNext = (dataCountReg == DC_MAX) ? dataCountReg : dataCountReg + DCW'(1);
        end
      end
      // A slave that ends the transaction in the error cycle makes our own end strobe redundant.
      ERROR:   stateNext = endTransactionIn ? RELEASE : ENDTX;
      ENDTX:   stateNext = RELEASE;
      RELEASE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grantIdxReg   <= '0;
      lastGrantReg  <= IDXW'(NUM_MASTERS - 1);
      beginCountReg <= '0;
      dataCountReg  <= '0;
      timeoutReg    <= 1'b0;
    end else begin
      state         <= stateNext;
      grantIdxReg   <= grantIdxNext;
      lastGrantReg  <= lastGrantNext;
      beginCountReg <= beginCountNext;
      dataCountReg  <= dataCountNext;
      timeoutReg    <= timeoutNext;
    end
  end

  logic grantEn;
  assign grantEn = (state == GRANT) || (state == ACTIVE) || (state == ERROR) || (state == ENDTX);

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : gLane
    bus_arbiter_lane #(.IDXW(IDXW), .LANE(i)) uLane (
      .grantEn  (grantEn),
      .grantIdx (grantIdxReg),
      .grant    (busGrantsOut[i])
    );
  end

  assign busErrorOut       = (state == ERROR);
  assign endTransactionOut = (state == ENDTX);
  assign timeoutOut        = timeoutReg;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: rotation, begin/data watchdogs, error-cycle end, async reset.

module tb_bus_arbiter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] busRequestsIn = '0;
  logic       beginTransactionIn = 1'b0;
  logic       endTransactionIn = 1'b0;
  logic       dataValidIn = 1'b0;
  logic [3:0] busGrantsOut;
  logic       busErrorOut, endTransactionOut, timeoutOut;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.NUM_MASTERS(4), .BEGIN_TIMEOUT(16), .DATA_TIMEOUT(8)) dut (
    .clock              (clock),
    .reset              (reset),
    .busRequestsIn      (busRequestsIn),
    .beginTransactionIn (beginTransactionIn),
    .endTransactionIn   (endTransactionIn),
    .dataValidIn        (dataValidIn),
    .busGrantsOut       (busGrantsOut),
    .busErrorOut        (busErrorOut),
    .endTransactionOut  (endTransactionOut),
    .timeoutOut         (timeoutOut)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkAll(input string tag, input logic [3:0] g, input logic e,
                        input logic en, input logic t);
    chk({tag, ".grant"}, 16'(busGrantsOut), 16'(g));
    chk({tag, ".err"},   16'(busErrorOut), 16'(e));
    chk({tag, ".end"},   16'(endTransactionOut), 16'(en));
    chk({tag, ".tmo"},   16'(timeoutOut), 16'(t));
  endtask

  logic [3:0] rot [5];

  initial begin
    rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000; rot[4] = 4'b0001;

    // reset state
    tick(); tick();
    chkAll("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // single transaction by master 0
    busRequestsIn = 4'b0001; tick();
    chkAll("t1.grant", 4'b0001, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t1.hold", 16'(busGrantsOut), 16'h1);
    beginTransactionIn = 1'b1; busRequestsIn = '0; tick(); beginTransactionIn = 1'b0;
    chk("t1.active", 16'(busGrantsOut), 16'h1);
    dataValidIn = 1'b1; tick(); tick(); tick(); dataValidIn = 1'b0;
    chkAll("t1.data", 4'b0001, 1'b0, 1'b0, 1'b0);
    endTransactionIn = 1'b1; tick(); endTransactionIn = 1'b0;
    chkAll("t1.release", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    chkAll("t1.idle", 4'b0000, 1'b0, 1'b0, 1'b0);

    // rotation with all masters requesting, fresh from reset
    reset = 1'b1; tick(); reset = 1'b0;
    busRequestsIn = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t2.grant%0d", k), 16'(busGrantsOut), 16'(rot[k]));
      beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0;
      chk($sformatf("t2.active%0d", k), 16'(busGrantsOut), 16'(rot[k]));
      endTransactionIn = 1'b1; tick(); endTransactionIn = 1'b0;
      chk($sformatf("t2.release%0d", k), 16'(busGrantsOut), 16'h0);
      if (k == 4) busRequestsIn = '0;
      tick();
      chk($sformatf("t2.idle%0d", k), 16'(busGrantsOut), 16'h0);
    end

    // begin timeout: last grant was 0, so master 2 wins over master 3
    busRequestsIn = 4'b1100; tick();
    chkAll("t3.grant", 4'b0100, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk($sformatf("t3.hold%0d", k), 16'({busGrantsOut, timeoutOut}), 16'({4'b0100, 1'b0}));
    end
    tick();
    chkAll("t3.timeout", 4'b0000, 1'b0, 1'b0, 1'b1);
    busRequestsIn = 4'b1000; tick();
    chkAll("t3.idle", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    chkAll("t3.next", 4'b1000, 1'b0, 1'b0, 1'b0);
    busRequestsIn = '0; tick();
    chkAll("t3.drop", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();

    // data timeout abort on master 0
    busRequestsIn = 4'b0001; tick();
    chk("t4.grant", 16'(busGrantsOut), 16'h1);
    beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0; busRequestsIn = '0;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("t4.wait%0d", k), 16'({busGrantsOut, busErrorOut}), 16'({4'b0001, 1'b0}));
    end
    tick();
    chkAll("t4.error", 4'b0001, 1'b1, 1'b0, 1'b1);
    tick();
    chkAll("t4.endtx", 4'b0001, 1'b0, 1'b1, 1'b0);
    tick();
    chkAll("t4.release", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();

    // periodic dataValid keeps master 1's transaction alive
    busRequestsIn = 4'b0010; tick();
    chk("t4b.grant", 16'(busGrantsOut), 16'h2);
    beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0; busRequestsIn = '0;
    for (int k = 0; k < 28; k++) begin
      dataValidIn = (k % 7 == 6);
      tick();
      chk($sformatf("t4b.live%0d", k), 16'({busGrantsOut, busErrorOut, timeoutOut}),
          16'({4'b0010, 2'b00}));
    end
    dataValidIn = 1'b0;
    endTransactionIn = 1'b1; tick(); endTransactionIn = 1'b0;
    chkAll("t4b.release", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();

    // slave ends the transaction during the error cycle: no ENDTX
    busRequestsIn = 4'b0100; tick();
    chk("t5.grant", 16'(busGrantsOut), 16'h4);
    beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0; busRequestsIn = '0;
    for (int k = 0; k < 7; k++) tick();
    tick();
    chkAll("t5.error", 4'b0100, 1'b1, 1'b0, 1'b1);
    endTransactionIn = 1'b1; tick(); endTransactionIn = 1'b0;
    chkAll("t5.release", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();

    // asynchronous reset mid-transaction
    busRequestsIn = 4'b1000; tick();
    beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0;
    chk("t6.active", 16'(busGrantsOut), 16'h8);
    #2 reset = 1'b1;
    #1;
    chkAll("t6.async", 4'b0000, 1'b0, 1'b0, 1'b0);
    busRequestsIn = 4'b1010;
    tick(); reset = 1'b0;
    tick();
    chkAll("t6.first", 4'b0010, 1'b0, 1'b0, 1'b0);
    busRequestsIn = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "bench timeout");
  end
endmodule
